// File: rtl/sequential_divider_pkg.sv
// Shared constants and FSM encoding for the iterative restoring divider.
// Default widths match the 4x4 array multiplier it checks against.
package sequential_divider_pkg;

  localparam int DIVIDEND_W = 8;
  localparam int DIVISOR_W  = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/sequential_divider_if.sv
// Start/busy/done request bus between a controller (master) and the divider (slave).
interface sequential_divider_if #(
  parameter int DIVIDEND_W = sequential_divider_pkg::DIVIDEND_W,
  parameter int DIVISOR_W  = sequential_divider_pkg::DIVISOR_W
);

  logic                  start;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  busy;
  logic                  done;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/sequential_divider_trial_subtract.sv
// Combinational compare-and-subtract of {rem, next dividend bit} against {0, divisor}.
// Ripple-carry add of the inverted divisor with carry-in 1; carry-out is "trial >= divisor".
module trial_subtract #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_rem,
  input  logic         i_bit,
  input  logic [W-1:0] i_dvsr,
  output logic [W-1:0] o_diff,
  output logic         o_ge
);

  logic [W:0]   w_a;
  logic [W:0]   w_b;
  logic [W+1:0] w_c;

  assign w_a    = {i_rem, i_bit};
  assign w_b    = ~{1'b0, i_dvsr};
  assign w_c[0] = 1'b1;

  for (genvar i = 0; i <= W; i++) begin : g_carry
    assign w_c[i+1] = (w_a[i] & w_b[i]) | (w_c[i] & (w_a[i] ^ w_b[i]));
  end

  // The top sum bit is zero whenever the difference is used, so only W bits leave.
  for (genvar i = 0; i < W; i++) begin : g_sum
    assign o_diff[i] = w_a[i] ^ w_b[i] ^ w_c[i];
  end

  assign o_ge = w_c[W+1];

endmodule

// File: rtl/sequential_divider.sv
// Restoring divider, one quotient bit per clock MSB first; done DIVIDEND_W+1 cycles after start
// (next cycle for divide-by-zero). start is only honoured in IDLE; results hold until the next DONE.
module sequential_divider #(
  parameter int DIVIDEND_W = sequential_divider_pkg::DIVIDEND_W,
  parameter int DIVISOR_W  = sequential_divider_pkg::DIVISOR_W,
  parameter int CNT_W      = 4
) (
  input logic                 clk,
  input logic                 reset,
  sequential_divider_if.slave bus
);

  import sequential_divider_pkg::*;

  div_state_t            r_state;
  div_state_t            w_next_state;
  logic [DIVIDEND_W-1:0] r_dq;
  logic [DIVISOR_W-1:0]  r_dvsr;
  logic [DIVISOR_W-1:0]  r_rem;
  logic [CNT_W-1:0]      r_cnt;
  logic [DIVIDEND_W-1:0] r_quotient;
  logic [DIVISOR_W-1:0]  r_remainder;
  logic                  r_dbz;

  logic [DIVISOR_W-1:0]  w_diff;
  logic                  w_ge;
  logic [DIVISOR_W-1:0]  w_rem_next;
  logic [DIVIDEND_W-1:0] w_dq_next;
  logic                  w_last;
  logic                  w_busy;
  logic                  w_done;

  trial_subtract #(.W(DIVISOR_W)) u_trial (
    .i_rem  (r_rem),
    .i_bit  (r_dq[DIVIDEND_W-1]),
    .i_dvsr (r_dvsr),
    .o_diff (w_diff),
    .o_ge   (w_ge)
  );

  assign w_rem_next = w_ge ? w_diff : {r_rem[DIVISOR_W-2:0], r_dq[DIVIDEND_W-1]};
  assign w_dq_next  = {r_dq[DIVIDEND_W-2:0], w_ge};
  assign w_last     = (r_cnt == CNT_W'(DIVIDEND_W - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next_state = (bus.divisor == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (w_last) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Result registers load only on the transition into DONE so they stay stable between pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dq        <= '0;
      r_dvsr      <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_dq   <= bus.dividend;
            r_dvsr <= bus.divisor;
            r_rem  <= '0;
            r_cnt  <= '0;
            if (bus.divisor == '0) begin
              r_quotient  <= '1;
              r_remainder <= '0;
              r_dbz       <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_dq  <= w_dq_next;
          r_rem <= w_rem_next;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_quotient  <= w_dq_next;
            r_remainder <= w_rem_next;
            r_dbz       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = w_busy;
  assign bus.done        = w_done;
  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_dbz;

endmodule
